// File: rtl/emmc_pkg.sv
// Shared definitions for the eMMC host CMD-line engine: response codes,
// frame lengths, CRC7 polynomial and the controller state encoding.
package emmc_pkg;

    localparam logic [1:0] RSP_NONE = 2'd0;
    localparam logic [1:0] RSP_R1   = 2'd1;
    localparam logic [1:0] RSP_R2   = 2'd2;
    localparam logic [1:0] RSP_R3   = 2'd3;

    localparam int FRAME_SHORT = 48;
    localparam int FRAME_LONG  = 136;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_NCR,
        ST_RX,
        ST_DONE,
        ST_GAP
    } state_t;

endpackage

// File: rtl/emmc_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled clock, MSB of the
// message first. clr returns the register to the zero seed.
module emmc_crc7
    import emmc_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[5:0], 1'b0} ^ ({7{din ^ crc[6]}} & CRC7_POLY);
        end
    end

endmodule

// File: rtl/emmc_cmd_serdes.sv
// Host-side eMMC CMD-line engine: sends a 48-bit command with CRC7, then
// waits for and captures a 48- or 136-bit card response and checks it.
module emmc_cmd_serdes
    import emmc_pkg::*;
#(
    parameter int RSP_TIMEOUT = 64,
    parameter int NCC         = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   rsp_type,
    output logic         rsp_valid,
    output logic [135:0] rsp_data,
    output logic         rsp_timeout,
    output logic         rsp_err,
    output logic         cmd_o,
    output logic         cmd_oe,
    input  logic         cmd_i
);

    localparam int NCR_W = $clog2(RSP_TIMEOUT + 1);
    localparam int GAP_W = $clog2(NCC + 1);

    state_t                  state;
    logic [1:0]              type_q;
    logic [46:0]             tx_shift;
    logic [7:0]              bit_pos;
    logic [NCR_W-1:0]        ncr_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic [FRAME_LONG-2:0]   rx_shift;
    logic [FRAME_LONG-1:0]   rx_next;
    logic [6:0]              crc_tx;
    logic [6:0]              crc_rx;
    logic                    accept;
    logic                    tx_crc_en;
    logic                    rx_crc_en;
    logic                    rx_last;
    logic                    rx_bad;

    assign accept  = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign rx_next = {rx_shift, cmd_i};

    // Each CRC is fed the bit being loaded/received. The start bit is always 0,
    // and shifting a 0 into a zero register leaves it zero, so clearing at
    // accept stands in for feeding it.
    assign tx_crc_en = (state == ST_TX) && (bit_pos < 8'd39);
    assign rx_crc_en = (state == ST_RX) &&
                       ((type_q == RSP_R2) ? ((bit_pos >= 8'd8) && (bit_pos <= 8'd127))
                                           : (bit_pos <= 8'd39));
    assign rx_last   = (type_q == RSP_R2) ? (bit_pos == 8'(FRAME_LONG - 1))
                                          : (bit_pos == 8'(FRAME_SHORT - 1));

    always_comb begin
        rx_bad = 1'b0;
        if (type_q == RSP_R2) begin
            rx_bad = rx_next[134] | ~rx_next[0] | (crc_rx != rx_next[7:1]);
        end else begin
            rx_bad = rx_next[46] | ~rx_next[0] |
                     ((type_q == RSP_R1) && (crc_rx != rx_next[7:1]));
        end
    end

    emmc_crc7 u_tx_crc (
        .clk  (clk),
        .rstn (rstn),
        .clr  (accept),
        .en   (tx_crc_en),
        .din  (tx_shift[46]),
        .crc  (crc_tx)
    );

    emmc_crc7 u_rx_crc (
        .clk  (clk),
        .rstn (rstn),
        .clr  (accept),
        .en   (rx_crc_en),
        .din  (cmd_i),
        .crc  (crc_rx)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b0;
            cmd_oe      <= 1'b0;
            cmd_o       <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_data    <= '0;
            type_q      <= RSP_NONE;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_pos     <= '0;
            ncr_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready   <= 1'b0;
                        state       <= ST_TX;
                        cmd_oe      <= 1'b1;
                        cmd_o       <= 1'b0;
                        tx_shift    <= {1'b1, cmd_index, cmd_arg, 7'd0, 1'b1};
                        type_q      <= rsp_type;
                        bit_pos     <= '0;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b0;
                        rsp_err     <= 1'b0;
                    end
                end
                ST_TX: begin
                    if (bit_pos == 8'd47) begin
                        cmd_oe <= 1'b0;
                        cmd_o  <= 1'b1;
                        if (type_q == RSP_NONE) begin
                            state     <= ST_DONE;
                            rsp_valid <= 1'b1;
                        end else begin
                            state   <= ST_NCR;
                            ncr_cnt <= '0;
                        end
                    end else begin
                        bit_pos <= bit_pos + 8'd1;
                        // Bit 40 onward: swap the finished CRC7 in ahead of the end bit.
                        if (bit_pos == 8'd39) begin
                            cmd_o    <= crc_tx[6];
                            tx_shift <= {crc_tx[5:0], 1'b1, 40'd0};
                        end else begin
                            cmd_o    <= tx_shift[46];
                            tx_shift <= {tx_shift[45:0], 1'b0};
                        end
                    end
                end
                ST_NCR: begin
                    if (!cmd_i) begin
                        state    <= ST_RX;
                        rx_shift <= '0;
                        bit_pos  <= 8'd1;
                    end else if (ncr_cnt == NCR_W'(RSP_TIMEOUT - 1)) begin
                        state       <= ST_DONE;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        ncr_cnt <= ncr_cnt + 1'b1;
                    end
                end
                ST_RX: begin
                    rx_shift <= rx_next[FRAME_LONG-2:0];
                    bit_pos  <= bit_pos + 8'd1;
                    if (rx_last) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= rx_next;
                        rsp_err   <= rx_bad;
                    end
                end
                ST_DONE: begin
                    state   <= ST_GAP;
                    gap_cnt <= '0;
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(NCC - 1)) begin
                        state     <= ST_IDLE;
                        cmd_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_emmc_cmd_serdes.sv
// Self-checking bench for emmc_cmd_serdes: drives commands, plays the card
// side of the CMD line and scoreboards transmitted frames and responses.
module tb_emmc_cmd_serdes;
    import emmc_pkg::*;

    typedef struct {
        logic [135:0] data;
        logic         timeout;
        logic         err;
    } rsp_exp_t;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   rsp_type = '0;
    logic         rsp_valid;
    logic [135:0] rsp_data;
    logic         rsp_timeout;
    logic         rsp_err;
    logic         cmd_o;
    logic         cmd_oe;
    logic         cmd_i = 1'b1;

    int           tests_run = 0;
    int           tests_failed = 0;
    logic [47:0]  tx_q[$];
    rsp_exp_t     rsp_q[$];
    logic [47:0]  tx_bits = '0;
    int           tx_n = 0;
    rsp_exp_t     mon_e;

    always #5 clk = ~clk;

    emmc_cmd_serdes #(.RSP_TIMEOUT(64), .NCC(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .rsp_type    (rsp_type),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .rsp_err     (rsp_err),
        .cmd_o       (cmd_o),
        .cmd_oe      (cmd_oe),
        .cmd_i       (cmd_i)
    );

    task automatic checkOutput(input string tag, input logic [135:0] observed,
                               input logic [135:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] crc7Model(input logic [135:0] bits, input int n);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = bits[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] buildCmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] t;
        t = {96'd0, 2'b01, idx, arg};
        return {2'b01, idx, arg, crc7Model(t, 40), 1'b1};
    endfunction

    function automatic logic [135:0] buildR1(input logic [5:0] idx, input logic [31:0] status);
        logic [135:0] t;
        t = {96'd0, 2'b00, idx, status};
        return {88'd0, 2'b00, idx, status, crc7Model(t, 40), 1'b1};
    endfunction

    function automatic logic [135:0] buildR2(input logic [119:0] payload);
        logic [135:0] t;
        t = {16'd0, payload};
        return {2'b00, 6'h3F, payload, crc7Model(t, 120), 1'b1};
    endfunction

    // Monitor: rebuilds each driven frame and scores every completion pulse.
    always @(negedge clk) begin
        if (cmd_oe === 1'b1) begin
            tx_bits = {tx_bits[46:0], cmd_o};
            tx_n++;
            if (tx_n == 48) begin
                checkOutput("tx_expected", tx_q.size() > 0, 1);
                if (tx_q.size() > 0) checkOutput("tx_frame", tx_bits, tx_q.pop_front());
                tx_n = 0;
            end
        end else begin
            tx_n = 0;
            if (cmd_oe === 1'b0) checkOutput("cmd_o_idle", cmd_o, 1);
        end
        if (rsp_valid === 1'b1) begin
            checkOutput("rsp_expected", rsp_q.size() > 0, 1);
            if (rsp_q.size() > 0) begin
                mon_e = rsp_q.pop_front();
                checkOutput("rsp_data", rsp_data, mon_e.data);
                checkOutput("rsp_timeout", rsp_timeout, mon_e.timeout);
                checkOutput("rsp_err", rsp_err, mon_e.err);
            end
        end
    end

    task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg,
                                 input logic [1:0] typ, input logic [47:0] exp_tx,
                                 input rsp_exp_t exp_rsp);
        int w;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        checkOutput("ready_wait", cmd_ready, 1);
        cmd_index = idx;
        cmd_arg   = arg;
        rsp_type  = typ;
        cmd_valid = 1'b1;
        tx_q.push_back(exp_tx);
        rsp_q.push_back(exp_rsp);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_index = 6'($urandom);
        cmd_arg   = $urandom;
        rsp_type  = 2'($urandom);
    endtask

    // card_delay < 0 keeps the card silent.
    task automatic runTransaction(input logic [5:0] idx, input logic [31:0] arg,
                                  input logic [1:0] typ, input logic [47:0] exp_tx,
                                  input logic [135:0] card_frame, input int card_len,
                                  input int card_delay, input logic exp_to, input logic exp_err);
        rsp_exp_t e;
        int       oe_cnt;
        int       since_drop;
        int       exp_lat;
        int       r;
        e.data    = (typ == RSP_NONE || card_delay < 0) ? 136'd0 : card_frame;
        e.timeout = exp_to;
        e.err     = exp_err;
        exp_lat   = (card_delay < 0) ? ((typ == RSP_NONE) ? 0 : 64) : card_delay + card_len;
        applyStimulus(idx, arg, typ, exp_tx, e);
        oe_cnt = 0;
        while (cmd_oe === 1'b1 && oe_cnt < 200) begin
            oe_cnt++;
            @(negedge clk);
        end
        checkOutput("oe_len", oe_cnt, 48);
        since_drop = 0;
        if (card_delay >= 0) begin
            repeat (card_delay) begin
                @(negedge clk);
                since_drop++;
            end
            for (int i = card_len - 1; i >= 0; i--) begin
                cmd_i = card_frame[i];
                @(negedge clk);
                since_drop++;
            end
            cmd_i = 1'b1;
        end
        while (rsp_valid !== 1'b1 && since_drop < 400) begin
            @(negedge clk);
            since_drop++;
        end
        checkOutput("rsp_valid_seen", rsp_valid, 1);
        checkOutput("rsp_latency", since_drop, exp_lat);
        r = 0;
        while (cmd_ready !== 1'b1 && r < 50) begin
            @(negedge clk);
            r++;
        end
        checkOutput("ready_gap", r, 9);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [135:0] r1;
        logic [135:0] r2;
        logic [135:0] one;
        int           seen;
        one = 136'd1;

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", cmd_ready, 0);
        checkOutput("rst_oe", cmd_oe, 0);
        checkOutput("rst_cmd_o", cmd_o, 1);
        checkOutput("rst_valid", rsp_valid, 0);
        checkOutput("rst_data", rsp_data, 0);
        checkOutput("rst_flags", {rsp_timeout, rsp_err}, 0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_rst", cmd_ready, 1);

        runTransaction(6'd0, 32'd0, RSP_NONE, 48'h400000000095, '0, 0, -1, 1'b0, 1'b0);

        r1 = buildR1(6'd17, 32'h00000900);
        runTransaction(6'd17, 32'd0, RSP_R1, 48'h510000000055, r1, 48, 4, 1'b0, 1'b0);

        runTransaction(6'd13, 32'h00010000, RSP_R1, buildCmd(6'd13, 32'h00010000), '0, 48, -1,
                       1'b1, 1'b0);

        runTransaction(6'd17, 32'h00000200, RSP_R1, buildCmd(6'd17, 32'h00000200),
                       r1 ^ (one << 3), 48, 2, 1'b0, 1'b1);
        runTransaction(6'd17, 32'h00000200, RSP_R1, buildCmd(6'd17, 32'h00000200),
                       r1 & ~one, 48, 2, 1'b0, 1'b1);

        runTransaction(6'd1, 32'h40FF8080, RSP_R3, buildCmd(6'd1, 32'h40FF8080),
                       {88'd0, 2'b00, 6'h3F, 32'h40FF8080, 7'h7F, 1'b1}, 48, 3, 1'b0, 1'b0);

        r2 = buildR2(120'h1501004D4D43313647_0A123456789A);
        runTransaction(6'd2, 32'h00010000, RSP_R2, buildCmd(6'd2, 32'h00010000), r2, 136, 2,
                       1'b0, 1'b0);
        runTransaction(6'd2, 32'h00010000, RSP_R2, buildCmd(6'd2, 32'h00010000),
                       r2 ^ (one << 130), 136, 5, 1'b0, 1'b0);
        runTransaction(6'd2, 32'h00010000, RSP_R2, buildCmd(6'd2, 32'h00010000),
                       r2 ^ (one << 60), 136, 0, 1'b0, 1'b1);

        // Abort a command mid-frame with a one-cycle reset.
        while (cmd_ready !== 1'b1) @(negedge clk);
        cmd_index = 6'd55;
        cmd_arg   = 32'd0;
        rsp_type  = RSP_R1;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("mid_oe_before", cmd_oe, 1);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_oe", cmd_oe, 0);
        checkOutput("mid_rst_cmd_o", cmd_o, 1);
        checkOutput("mid_rst_ready", cmd_ready, 0);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("mid_ready_after", cmd_ready, 1);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        checkOutput("mid_no_rsp", seen, 0);

        runTransaction(6'd8, 32'h000001AA, RSP_R1, 48'h48000001AA87,
                       buildR1(6'd8, 32'h000001AA), 48, 4, 1'b0, 1'b0);

        checkOutput("tx_q_drained", tx_q.size(), 0);
        checkOutput("rsp_q_drained", rsp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/emmc_cmd_serdes.md
Name: emmc_cmd_serdes

Overview:
- Host-side eMMC CMD-line engine. Serialises a 48-bit command frame with generated CRC7, releases the line, then waits for and deserialises the card response (48- or 136-bit) and checks it.
- Sits directly upstream of the bench CMD-line delay element. cmd_o/cmd_oe/cmd_i are joined into the bidirectional CMD net at the bench top; the line is pulled up.
- Synthesisable; also used in the host model of the bench.

Parameters:
- RSP_TIMEOUT, 64: max card-clock cycles (NCR) waited for a response start bit before timeout.
- NCC, 8: idle cycles enforced after each transaction before cmd_ready reasserts.

Ports:
- clk  in  1  card clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only.
- cmd_index  in  6  command index.
- cmd_arg  in  32  command argument.
- rsp_type  in  2  0 = none, 1 = 48-bit with CRC (R1/R1b), 2 = 136-bit (R2), 3 = 48-bit no CRC (R3).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  136  raw received frame, right-aligned; for 48-bit responses [135:48] = 0.
- rsp_timeout  out  1  valid with rsp_valid.
- rsp_err  out  1  CRC, transmission-bit or end-bit error; valid with rsp_valid.
- cmd_o  out  1  serial out; 1 whenever cmd_oe = 0.
- cmd_oe  out  1  line drive enable.
- cmd_i  in  1  sampled CMD line.

Behaviour:
- Reset values: cmd_ready = 0 during reset, 1 the first cycle after release (IDLE). rsp_valid, rsp_timeout, rsp_err, cmd_oe = 0. cmd_o = 1. rsp_data = 0.
- States: IDLE → TX → (NCR → RX) → DONE → GAP → IDLE.
- Accept on cmd_valid & cmd_ready at edge N. Index, argument and type are latched; later input changes are ignored.
- TX:
  - cmd_oe = 1 for exactly 48 cycles, from edge N+1.
  - Bit order MSB first: start 0, transmission 1, index[5:0], arg[31:0], CRC7, end 1.
  - CRC7 uses polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
  - cmd_oe drops on the cycle after the end bit.
  - If rsp_type = 0, go to DONE directly.
- NCR:
  - Counter starts at 0 on the first released cycle; cmd_i is sampled each edge.
  - cmd_i = 0 → RX; that start bit is stored as frame bit [L-1].
  - If RSP_TIMEOUT cycles elapse with cmd_i = 1 → DONE with rsp_timeout = 1 and rsp_data = 0.
- RX:
  - Shift in the remaining L-1 bits, where L = 48 or 136.
  - Checks:
    - Frame bit [L-2] (transmission bit) must be 0.
    - Bit 0 (end bit) must be 1.
    - Type 1: CRC7 over bits [47:8] must equal [7:1].
    - Type 2: CRC7 over bits [127:8] must equal [7:1]; bits [133:128] are excluded.
    - Type 3: no CRC check.
  - Any failed check → rsp_err = 1.
- DONE: rsp_valid = 1 for one cycle. rsp_data, rsp_timeout and rsp_err hold until the next accept.
- GAP: NCC cycles with cmd_oe = 0, then IDLE. cmd_valid is ignored outside IDLE.
- A low cmd_i during TX or GAP is ignored.
- rstn low mid-transaction: at that edge go to IDLE outputs (cmd_oe = 0, cmd_o = 1). The 1-cycle cmd_ready = 0 during reset applies. No rsp_valid; partial state is discarded.
- Counter widths: $clog2(RSP_TIMEOUT+1) and 8 bits for bit position; no wrap.

Decomposition:
- Package emmc_pkg:
  - rsp_type codes (RSP_NONE / RSP_R1 / RSP_R2 / RSP_R3).
  - Frame lengths 48/136.
  - CRC7 polynomial 7'h09.
  - State enum.
- Sub-module emmc_crc7: serial CRC7 with clr, en, din and 7-bit crc out. Instanced once for TX and once for RX.

Test Plan:
- CMD0, arg 0, rsp_type 0, accept at edge N:
  - cmd_oe high for edges N+1..N+48.
  - Serial frame is 0x400000000095.
  - rsp_valid at N+49 with rsp_timeout = 0, rsp_err = 0.
  - cmd_ready returns 8 cycles after DONE.
- CMD17, arg 0, type 1:
  - TX frame is 0x510000000055.
  - Card model returns a 48-bit R1 with index 17, status 0x00000900, correct CRC, 4 cycles after release.
  - rsp_data[47:0] equals that frame; rsp_err = 0.
- Type 1 with the card silent → rsp_valid exactly 64 cycles after cmd_oe falls, rsp_timeout = 1, rsp_data = 0.
- R1 response with one CRC bit flipped, then a separate run with end bit 0 → rsp_err = 1 each time, rsp_timeout = 0.
- Type 2: card returns a 136-bit R2 with valid CRC over [127:8]; then repeat with bit 130 flipped (reserved bits) → rsp_err = 0 in both runs.
- rstn low for 1 cycle at TX bit 20:
  - cmd_oe = 0 next edge; no rsp_valid.
  - cmd_ready = 1 the cycle after reset releases.
  - Next CMD8, arg 0x1AA, type 1 transmits 0x48000001AA87.
